// File: rtl/sync_fifo_cnt_pkg.sv
// Shared operation encoding for the counter-based FIFO.
// Pure types/functions; no state, no latency.
package sync_fifo_cnt_pkg;

  // Bit 1 = read accepted, bit 0 = write accepted on this edge.
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_WR   = 2'b01,
    OP_RD   = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

  function automatic fifo_op_e decode_op(input logic wr_acc, input logic rd_acc);
    return fifo_op_e'({rd_acc, wr_acc});
  endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// Storage array: one write port, one registered read port cleared by reset.
// Read data appears one cycle after rd; holds when rd is low; no backpressure.
module sync_fifo_mem #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DATA_DEPTH = 8,
  parameter int unsigned ADDR_W     = $clog2(DATA_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd,
  input  logic [ADDR_W-1:0]     rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [DATA_DEPTH];

  // Array carries no reset so it can map onto plain RAM cells.
  always_ff @(posedge clk) begin
    if (wr) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (rd) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/sync_fifo_cnt.sv
// Single-clock FIFO; flags decode from an occupancy counter exported as fifo_cnt.
// Read data 1 cycle after accept; writes when full and reads when empty are dropped.
module sync_fifo_cnt
  import sync_fifo_cnt_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DATA_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [DATA_WIDTH-1:0]         data_in,
  input  logic                          rd_en,
  input  logic                          wr_en,
  output logic [DATA_WIDTH-1:0]         data_out,
  output logic                          empty,
  output logic                          full,
  output logic [$clog2(DATA_DEPTH):0]   fifo_cnt
);

  localparam int unsigned ADDR_W = $clog2(DATA_DEPTH);
  localparam int unsigned CNT_W  = ADDR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_DEPTH);

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [CNT_W-1:0]  cnt;
  logic              wr_acc;
  logic              rd_acc;
  fifo_op_e          op;

  assign empty  = (cnt == '0);
  assign full   = (cnt == CNT_FULL);
  assign wr_acc = wr_en & ~full;
  assign rd_acc = rd_en & ~empty;
  assign op     = decode_op(wr_acc, rd_acc);

  // Pointers wrap on their own since DATA_DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (rd_acc) rd_ptr <= rd_ptr + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else begin
      case (op)
        OP_WR:   cnt <= cnt + CNT_W'(1);
        OP_RD:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Accepted read and write never share an address: equal pointers means empty or full.
  sync_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DATA_DEPTH (DATA_DEPTH),
    .ADDR_W     (ADDR_W)
  ) u_mem (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr      (wr_acc),
    .wr_addr (wr_ptr),
    .wr_data (data_in),
    .rd      (rd_acc),
    .rd_addr (rd_ptr),
    .rd_data (data_out)
  );

  assign fifo_cnt = cnt;

endmodule

// File: tb/tb_sync_fifo_cnt.sv
// Bench for sync_fifo_cnt: directed vector table, async reset sequence,
// then randomized traffic against a queue model.
module tb_sync_fifo_cnt;

  localparam int DW = 8;
  localparam int DD = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic          rd_en = 1'b0;
  logic          wr_en = 1'b0;
  logic [DW-1:0] data_out;
  logic          empty;
  logic          full;
  logic [3:0]    fifo_cnt;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic          wr;
    logic          rd;
    logic [DW-1:0] din;
    logic [3:0]    cnt;
    logic          emp;
    logic          ful;
    logic [DW-1:0] dout;
  } vec_t;

  vec_t          vecs[$];
  logic [DW-1:0] model_q[$];
  logic [DW-1:0] model_dout;

  sync_fifo_cnt #(.DATA_WIDTH(DW), .DATA_DEPTH(DD)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .data_in  (data_in),
    .rd_en    (rd_en),
    .wr_en    (wr_en),
    .data_out (data_out),
    .empty    (empty),
    .full     (full),
    .fifo_cnt (fifo_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  function automatic void add(input logic wr, input logic rd, input logic [DW-1:0] din,
                              input int cnt, input logic [DW-1:0] dout);
    vec_t v;
    v.wr = wr; v.rd = rd; v.din = din;
    v.cnt = 4'(cnt); v.emp = (cnt == 0); v.ful = (cnt == DD); v.dout = dout;
    vecs.push_back(v);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Queue model: flags are taken from occupancy before the edge.
  task automatic model_step(input logic wr, input logic rd, input logic [DW-1:0] din);
    bit was_full  = (model_q.size() == DD);
    bit was_empty = (model_q.size() == 0);
    if (rd && !was_empty) model_dout = model_q.pop_front();
    if (wr && !was_full)  model_q.push_back(din);
  endtask

  initial begin
    // Directed table: fill, overfill, drain, underflow, streaming, full/empty with both.
    for (int i = 0; i < 8; i++) add(1, 0, 8'hA0 + 8'(i), i + 1, 8'h00);
    add(1, 0, 8'hEE, 8, 8'h00);
    for (int i = 0; i < 8; i++) add(0, 1, 8'h00, 7 - i, 8'hA0 + 8'(i));
    add(0, 1, 8'h00, 0, 8'hA7);
    add(1, 1, 8'hB0, 1, 8'hA7);
    for (int i = 1; i < 4; i++) add(1, 0, 8'hB0 + 8'(i), i + 1, 8'hA7);
    for (int i = 0; i < 4; i++) add(1, 1, 8'hC0 + 8'(i), 4, 8'hB0 + 8'(i));
    add(1, 1, 8'hC4, 4, 8'hC0);
    add(1, 1, 8'hC5, 4, 8'hC1);
    for (int i = 0; i < 4; i++) add(1, 0, 8'hD0 + 8'(i), 5 + i, 8'hC1);
    add(1, 1, 8'hEE, 7, 8'hC2);
    add(0, 1, 8'h00, 6, 8'hC3);
    add(0, 1, 8'h00, 5, 8'hC4);
    add(0, 1, 8'h00, 4, 8'hC5);
    for (int i = 0; i < 4; i++) add(0, 1, 8'h00, 3 - i, 8'hD0 + 8'(i));

    #3;
    chk("reset_cnt",   32'(fifo_cnt), 0);
    chk("reset_empty", 32'(empty),    1);
    chk("reset_full",  32'(full),     0);
    chk("reset_dout",  32'(data_out), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    foreach (vecs[i]) begin
      wr_en = vecs[i].wr; rd_en = vecs[i].rd; data_in = vecs[i].din;
      tick();
      chk($sformatf("vec%0d_cnt", i),   32'(fifo_cnt), 32'(vecs[i].cnt));
      chk($sformatf("vec%0d_empty", i), 32'(empty),    32'(vecs[i].emp));
      chk($sformatf("vec%0d_full", i),  32'(full),     32'(vecs[i].ful));
      chk($sformatf("vec%0d_dout", i),  32'(data_out), 32'(vecs[i].dout));
    end

    // Async reset mid-stream at occupancy 5, between clock edges.
    for (int i = 0; i < 5; i++) begin
      wr_en = 1'b1; rd_en = 1'b0; data_in = 8'h50 + 8'(i);
      tick();
    end
    wr_en = 1'b0;
    chk("pre_arst_cnt",  32'(fifo_cnt), 5);
    chk("pre_arst_dout", 32'(data_out), 32'h0D3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_cnt",   32'(fifo_cnt), 0);
    chk("arst_empty", 32'(empty),    1);
    chk("arst_full",  32'(full),     0);
    chk("arst_dout",  32'(data_out), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Random traffic with shifting bias to visit both full and empty.
    model_q.delete();
    model_dout = '0;
    for (int ph = 0; ph < 3; ph++) begin
      int wbias = (ph == 0) ? 75 : (ph == 1) ? 25 : 50;
      int rbias = (ph == 0) ? 25 : (ph == 1) ? 75 : 50;
      for (int n = 0; n < 150; n++) begin
        logic          w = ($urandom_range(0, 99) < wbias);
        logic          r = ($urandom_range(0, 99) < rbias);
        logic [DW-1:0] d = DW'($urandom);
        wr_en = w; rd_en = r; data_in = d;
        tick();
        model_step(w, r, d);
        chk("rnd_cnt",   32'(fifo_cnt), 32'(model_q.size()));
        chk("rnd_empty", 32'(empty),    32'(model_q.size() == 0));
        chk("rnd_full",  32'(full),     32'(model_q.size() == DD));
        chk("rnd_dout",  32'(data_out), 32'(model_dout));
      end
    end
    wr_en = 1'b0; rd_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
